// File: rtl/bram_sdp_be.sv
// Simple-dual-port block RAM with byte-lane writes, optional output register and a clear sequencer.
// Define BRAM_SDP_BE_BYPASS_EN for write-first forwarding on a same-address read/write; default is read-first.
module bram_sdp_be #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 1024,
  parameter int              BYTE_W    = 8,
  parameter string           INIT_F    = "",
  parameter int              OUT_REG   = 0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
  localparam int             NBYTES    = WIDTH / BYTE_W,
  localparam int             ADDRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NBYTES-1:0] be,
  input  logic [ADDRW-1:0]  addr_write,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              re,
  input  logic [ADDRW-1:0]  addr_read,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  input  logic              clear,
  output logic              busy
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW:0]   DEPTH_X   = (ADDRW + 1)'(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_next;
  logic [ADDRW-1:0] cnt, cnt_next;

  logic [WIDTH-1:0] mem [DEPTH];

  assign busy = (state == CLEAR);

  logic wr_ok, rd_fire, rd_in_range;
  assign wr_ok       = we && !busy && ({1'b0, addr_write} < DEPTH_X);
  assign rd_fire     = re && !busy;
  assign rd_in_range = ({1'b0, addr_read} < DEPTH_X);

  // Clear sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ADDRW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single physical write port shared between the user and the clear sequencer
  logic              mem_we;
  logic [ADDRW-1:0]  w_addr;
  logic [WIDTH-1:0]  w_data;
  logic [NBYTES-1:0] w_be;

  always_comb begin
    mem_we = wr_ok;
    w_addr = addr_write;
    w_data = data_in;
    w_be   = be;
    if (busy) begin
      mem_we = 1'b1;
      w_addr = cnt;
      w_data = CLEAR_VAL;
      w_be   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_be[i]) mem[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  logic [WIDTH-1:0] rd_word;

`ifdef BRAM_SDP_BE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = wr_ok && (addr_write == addr_read);
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bypass
      assign rd_word[gi*BYTE_W +: BYTE_W] = (bypass_hit && be[gi])
                                           ? data_in[gi*BYTE_W +: BYTE_W]
                                           : mem[addr_read][gi*BYTE_W +: BYTE_W];
    end
  endgenerate
`else
  assign rd_word = mem[addr_read];
`endif

  // Read stage 1: the BRAM output register
  logic [WIDTH-1:0] rd_data;
  logic             rd_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd_fire;
      if (rd_fire) rd_data <= rd_in_range ? rd_word : '0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_q;
      logic             vld_q;
      // Not gated by busy so reads already in flight drain during a clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= rd_vld;
          if (rd_vld) out_q <= rd_data;
        end
      end
      assign data_out   = out_q;
      assign data_valid = vld_q;
    end else begin : g_no_out_reg
      assign data_out   = rd_data;
      assign data_valid = rd_vld;
    end
  endgenerate

endmodule
